blink_encoder: RTL
==================

# blink_encoder

Output-side companion to the push-button edge detector: consumes one-cycle event pulses and renders each as one visible LED blink, paced by a slow timebase tick from the clock-divider counters. Events arriving faster than they can be shown are queued in a saturating pending counter, so N presses always produce exactly N blinks. The block sits between the button/event logic and a board LED, inside the 50 MHz clock domain.

## Interface
- ON_TICKS, 2, blink on-time in tick periods; legal range 1..256
- OFF_TICKS, 2, off-time after each blink in tick periods; legal range 1..256
- CNT_W, 3, pending-counter width; queue depth is 2^CNT_W-1
- clk  input  1  system clock (50 MHz)
- reset_n  input  1  reset, asynchronous and active-low
- tick  input  1  timebase enable, one clk wide, e.g. counter terminal count
- event  input  1  one-clk event pulse to be blinked
- clr  input  1  synchronous clear: abort the blink, empty the queue, clear overflow
- led  output  1  blink output
- busy  output  1  high whenever the state is not IDLE
- pending  output  CNT_W  number of queued blinks not yet started
- overflow  output  1  sticky flag: an event was dropped because the queue was full

## Operation
- States:
  - IDLE: led off.
  - ON: led lit.
  - OFF: led off, enforced gap.
- Phase counter counts ticks within ON/OFF. Its width is $clog2(max(ON_TICKS,OFF_TICKS)) bits, minimum 1.
- IDLE -> ON: on a tick with pending != 0. Phase <= 0, pending decrements by 1.
- ON: each tick increments phase. On a tick with phase == ON_TICKS-1: go to OFF, phase <= 0.
- OFF: each tick increments phase. On a tick with phase == OFF_TICKS-1:
  - pending != 0: go to ON and decrement pending (back-to-back blink, no IDLE cycle).
  - otherwise: go to IDLE.
- Without tick, state and phase hold; only event/clr act.
- pending update each clk, where inc = event and pending != max, and dec = a start transition this cycle:
  - inc and dec together: net unchanged.
  - inc only: +1.
  - dec only: -1.
- Event while pending == 2^CNT_W-1 and no dec that cycle: the event is dropped and overflow <= 1. An event at full with a simultaneous dec is accepted.
- overflow stays set until reset or clr.
- clr has priority over everything: next clk state IDLE, phase 0, pending 0, overflow 0, led off. An event in the same cycle as clr is discarded.

## Timing
- Reset values (asserted asynchronously):
  - state IDLE, phase 0, pending 0, overflow 0, busy 0
  - led 0, or 1 under the macro below
- All outputs are registered; no combinational path from inputs to outputs.
- event -> pending visible: 1 clk.
- Blink start: led rises 1 clk after the first tick that sees pending != 0.
  - If event and tick arrive in the same cycle in IDLE, that tick does not start the blink (pending still 0); the next tick does.
- led high for exactly ON_TICKS tick periods. Minimum spacing from one blink's rising edge to the next is (ON_TICKS+OFF_TICKS) tick periods.
- Reset mid-blink: led returns to its off value immediately and asynchronously.

## Configuration
- BLINK_LED_ACTIVE_LOW_EN defined: led is driven low while lit and high otherwise, including its reset value of 1. For active-low board LEDs and segments.
- Undefined: led is active-high with reset value 0.
- busy, pending and overflow are unaffected by the macro.

## Test plan
- All scenarios use ON_TICKS=2, OFF_TICKS=2, CNT_W=3, and tick every 4 clks.
- Reset: hold reset_n=0 mid-blink -> led=0, busy=0, pending=0, overflow=0 asynchronously; outputs stay there until events arrive.
- Single event -> pending=1 the next clk; led high for exactly 8 clks starting 1 clk after the next tick; busy falls 8 clks after led falls; pending=0.
- 3 events 1 clk apart -> 3 blinks, each 8 clks high with 8-clk gaps; no IDLE cycle between blinks; pending steps 3,2,1,0.
- 9 events while idle with tick held low -> pending saturates at 7, overflow=1; enabling tick yields exactly 7 blinks; overflow stays 1.
- pending=7 in OFF, event coincident with the tick that starts the next blink -> pending stays 7, overflow stays 0.
- clr asserted during ON with pending=4 -> next clk led=0, state IDLE, pending=0, overflow=0; a concurrent event is ignored; no further blinks.

Source files
------------

// File: rtl/blink_encoder_if.sv
// blink_encoder_if: event/tick inputs and LED/status outputs of the blink encoder.
interface blink_encoder_if #(parameter int CNT_W = 3);
  logic tick;
  logic evt;
  logic clr;
  logic led;
  logic busy;
  logic [CNT_W-1:0] pending;
  logic overflow;
  modport master(output tick, evt, clr, input led, busy, pending, overflow);
  modport slave(input tick, evt, clr, output led, busy, pending, overflow);
endinterface

// File: rtl/blink_encoder.sv
// blink_encoder: renders each queued event pulse as one tick-paced LED blink.
// Define BLINK_LED_ACTIVE_LOW_EN for an active-low led (reset value 1).
module blink_encoder #(
  parameter int ON_TICKS = 2,
  parameter int OFF_TICKS = 2,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic reset_n,
  blink_encoder_if.slave bus
);
  localparam int MAX_T = ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS;
  localparam int PH_W = MAX_T > 1 ? $clog2(MAX_T) : 1;
  localparam logic [PH_W-1:0] ON_LAST = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
`ifdef BLINK_LED_ACTIVE_LOW_EN
  localparam logic LED_ON = 1'b0;
`else
  localparam logic LED_ON = 1'b1;
`endif
  localparam logic LED_OFF = ~LED_ON;
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state;
  logic [PH_W-1:0] phase;
  logic full, phase_end, start, inc, drop;
  always_comb begin
    full = &bus.pending;
    phase_end = phase == (state == ON ? ON_LAST : OFF_LAST);
    start = bus.tick && bus.pending != '0 && (state == IDLE || (state == OFF && phase_end));
    // a full queue still accepts an event when a blink starts the same cycle
    inc = bus.evt && (!full || start);
    drop = bus.evt && full && !start;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      phase <= '0;
      bus.pending <= '0;
      bus.overflow <= 1'b0;
      bus.led <= LED_OFF;
      bus.busy <= 1'b0;
    end else if (bus.clr) begin
      state <= IDLE;
      phase <= '0;
      bus.pending <= '0;
      bus.overflow <= 1'b0;
      bus.led <= LED_OFF;
      bus.busy <= 1'b0;
    end else begin
      bus.pending <= bus.pending + CNT_W'(inc) - CNT_W'(start);
      if (drop) bus.overflow <= 1'b1;
      if (bus.tick) begin
        phase <= (state == IDLE || phase_end) ? '0 : phase + 1'b1;
        if (start) begin
          state <= ON;
          bus.led <= LED_ON;
          bus.busy <= 1'b1;
        end else if (state == ON && phase_end) begin
          state <= OFF;
          bus.led <= LED_OFF;
        end else if (state == OFF && phase_end) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      end
    end
  end
endmodule
